// File: rtl/ddr3_pkg.sv
// ============================================================================
// Module : ddr3_pkg
// Brief  : Command codes and arbiter state encoding shared by ddr3_rw_arb.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ddr3_pkg;

  localparam logic [3:0] CMD_NOP   = 4'h0;
  localparam logic [3:0] CMD_READ  = 4'h1;
  localparam logic [3:0] CMD_WRITE = 4'h2;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_READY   = 3'd1,
    ST_WR_CMD  = 3'd2,
    ST_WR_DATA = 3'd3,
    ST_RD_CMD  = 3'd4,
    ST_RD_DATA = 3'd5
  } state_t;

endpackage

`default_nettype wire

// File: rtl/ddr3_beat_cnt.sv
// ============================================================================
// Module : ddr3_beat_cnt
// Brief  : 4-bit saturating burst beat counter; done flags the final beat.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ddr3_beat_cnt #(
  parameter int BURST_BEATS = 2
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clr,
  input  logic i_inc,
  output logic o_done
);

  localparam logic [3:0] c_LAST = 4'(BURST_BEATS - 1);

  logic [3:0] cnt_q;
  logic [3:0] cnt_d;

  // Clear wins over increment so a state exit on the last beat restarts at 0.
  always_comb begin
    cnt_d = cnt_q;
    if (i_clr) begin
      cnt_d = 4'd0;
    end else if (i_inc && (cnt_q != 4'hF)) begin
      cnt_d = cnt_q + 4'd1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q <= 4'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign o_done = i_inc && (cnt_q == c_LAST);

endmodule

`default_nettype wire

// File: rtl/ddr3_rw_arb.sv
// ============================================================================
// Module : ddr3_rw_arb
// Brief  : Read/write request arbiter in front of a DDR3 controller native
//          command/data interface. Fixed write priority by default; define
//          DDR3_RR_ARB_EN for round-robin between reads and writes.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ddr3_rw_arb
  import ddr3_pkg::*;
#(
  parameter int ADDR_W      = 26,
  parameter int DATA_W      = 64,
  parameter int BURST_BEATS = 2
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_ddr_init_done,
  input  logic              i_wr_req,
  input  logic [ADDR_W-1:0] i_wr_addr,
  output logic              o_wr_ack,
  output logic              o_wr_data_rd,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic              i_rd_req,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic              o_rd_ack,
  output logic [DATA_W-1:0] o_rd_data,
  output logic              o_rd_valid,
  output logic [3:0]        o_cmd,
  output logic              o_cmd_valid,
  input  logic              i_cmd_rdy,
  output logic [ADDR_W-1:0] o_addr,
  input  logic              i_datain_rdy,
  output logic [DATA_W-1:0] o_write_data,
  input  logic [DATA_W-1:0] i_read_data,
  input  logic              i_read_data_valid,
  output logic              o_busy,
  output logic              o_abort
);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              wr_ack_q, wr_ack_d;
  logic              rd_ack_q, rd_ack_d;
  logic              abort_q, abort_d;
  logic              rd_valid_q;
  logic [DATA_W-1:0] rd_data_q;

  logic w_wr_beat;
  logic w_rd_beat;
  logic w_beat_done;
  logic w_wr_prio;
  logic w_grant_wr;
  logic w_grant_rd;

  // Beats are suppressed in the abort cycle so nothing is popped or returned
  // for a transfer that is being torn down.
  assign w_wr_beat  = (state_q == ST_WR_DATA) && i_datain_rdy && i_ddr_init_done;
  assign w_rd_beat  = (state_q == ST_RD_DATA) && i_read_data_valid && i_ddr_init_done;
  assign w_grant_wr = i_wr_req && (!i_rd_req || w_wr_prio);
  assign w_grant_rd = i_rd_req && !w_grant_wr;

`ifdef DDR3_RR_ARB_EN
  logic last_wr_q, last_wr_d;

  always_comb begin
    last_wr_d = last_wr_q;
    if ((state_q == ST_READY) && i_ddr_init_done && (i_wr_req || i_rd_req)) begin
      last_wr_d = w_grant_wr;
    end
  end

  // Resetting to "last grant was a read" makes the first contested grant a write.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      last_wr_q <= 1'b0;
    end else begin
      last_wr_q <= last_wr_d;
    end
  end

  assign w_wr_prio = ~last_wr_q;
`else
  assign w_wr_prio = 1'b1;
`endif

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    wr_ack_d = 1'b0;
    rd_ack_d = 1'b0;
    abort_d  = 1'b0;
    if ((state_q != ST_IDLE) && !i_ddr_init_done) begin
      state_d = ST_IDLE;
      abort_d = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (i_ddr_init_done) state_d = ST_READY;
        end
        ST_READY: begin
          if (w_grant_wr) begin
            state_d  = ST_WR_CMD;
            wr_ack_d = 1'b1;
            addr_d   = i_wr_addr;
          end else if (w_grant_rd) begin
            state_d  = ST_RD_CMD;
            rd_ack_d = 1'b1;
            addr_d   = i_rd_addr;
          end
        end
        ST_WR_CMD: begin
          if (i_cmd_rdy) state_d = ST_WR_DATA;
        end
        ST_WR_DATA: begin
          if (w_beat_done) state_d = ST_READY;
        end
        ST_RD_CMD: begin
          if (i_cmd_rdy) state_d = ST_RD_DATA;
        end
        ST_RD_DATA: begin
          if (w_beat_done) state_d = ST_READY;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      wr_ack_q   <= 1'b0;
      rd_ack_q   <= 1'b0;
      abort_q    <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wr_ack_q   <= wr_ack_d;
      rd_ack_q   <= rd_ack_d;
      abort_q    <= abort_d;
      rd_valid_q <= w_rd_beat;
      if (w_rd_beat) rd_data_q <= i_read_data;
    end
  end

  ddr3_beat_cnt #(
    .BURST_BEATS (BURST_BEATS)
  ) u_beat_cnt (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_clr   (state_d != state_q),
    .i_inc   (w_wr_beat || w_rd_beat),
    .o_done  (w_beat_done)
  );

  assign o_cmd        = (state_q == ST_WR_CMD) ? CMD_WRITE :
                        (state_q == ST_RD_CMD) ? CMD_READ  : CMD_NOP;
  assign o_cmd_valid  = ((state_q == ST_WR_CMD) || (state_q == ST_RD_CMD)) && i_ddr_init_done;
  assign o_addr       = addr_q;
  assign o_wr_ack     = wr_ack_q;
  assign o_rd_ack     = rd_ack_q;
  assign o_wr_data_rd = w_wr_beat;
  assign o_write_data = (state_q == ST_WR_DATA) ? i_wr_data : '0;
  assign o_rd_valid   = rd_valid_q;
  assign o_rd_data    = rd_data_q;
  assign o_abort      = abort_q;
  assign o_busy       = (state_q == ST_WR_CMD) || (state_q == ST_WR_DATA) ||
                        (state_q == ST_RD_CMD) || (state_q == ST_RD_DATA);

endmodule

`default_nettype wire
